// File: rtl/spi_xform_slave_if.sv
// SPI pins plus the receive-side status outputs of the transforming SPI slave.
// The slave modport is what the block sees. The master modport is what a bus driver sees.
interface spi_xform_slave_if #(
   parameter int WIDTH = 8
);
   logic             sck;
   logic             ss;
   logic             mosi;
   logic [1:0]       mode;
   logic             miso;
   logic             rx_valid;
   logic [WIDTH-1:0] rx_data;
   logic             frame_err;

   modport slave (
      input  sck, ss, mosi, mode,
      output miso, rx_valid, rx_data, frame_err
   );

   modport master (
      output sck, ss, mosi, mode,
      input  miso, rx_valid, rx_data, frame_err
   );
endinterface

// File: rtl/spi_xform_slave.sv
// Mode-0 SPI slave. It receives a word, then shifts out a transformed copy of that word.
// The transform is bit-reverse, echo, invert, or reverse+invert.
module spi_xform_slave #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input logic              clock,
   input logic              reset,
   spi_xform_slave_if.slave bus
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RX, TX} state_t;

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_prev;
   logic                   sck_s;
   logic                   ss_s;
   logic                   mosi_s;
   logic                   sck_rise;
   logic                   sck_fall;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-2:0] shift_q, shift_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             miso_q, miso_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic [WIDTH-1:0] word_in;

   function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] w, input logic [1:0] m);
      logic [WIDTH-1:0] rev;
      logic [WIDTH-1:0] res;
      rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev[i] = w[WIDTH-1-i];
      end
      case (m)
         2'b00:   res = rev;
         2'b01:   res = w;
         2'b10:   res = ~w;
         default: res = ~rev;
      endcase
      return res;
   endfunction

   // The synchronizers reset to the idle bus levels, so releasing reset never creates a false edge or select.
   always_ff @(posedge clock) begin
      if (reset) begin
         sck_sync  <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
         sck_prev  <= sck_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign word_in  = {shift_q, mosi_s};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         tx_q        <= '0;
         rx_data_q   <= '0;
         miso_q      <= 1'b1;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         rx_data_q   <= rx_data_d;
         miso_q      <= miso_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // A released select wins over any edge in the same clock. A word that completes as ss rises is therefore lost.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      rx_data_d   = rx_data_q;
      miso_d      = miso_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            miso_d = 1'b1;
            if (!ss_s) begin
               state_d = RX;
            end
         end

         RX: begin
            if (ss_s) begin
               state_d     = IDLE;
               cnt_d       = '0;
               miso_d      = 1'b1;
               frame_err_d = (cnt_q != '0);
            end else begin
               if (sck_fall) begin
                  miso_d = 1'b1;
               end
               if (sck_rise) begin
                  shift_d = word_in[WIDTH-2:0];
                  if (cnt_q == LAST) begin
                     rx_data_d  = word_in;
                     rx_valid_d = 1'b1;
                     tx_d       = xform(word_in, bus.mode);
                     cnt_d      = '0;
                     state_d    = TX;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end

         TX: begin
            if (ss_s) begin
               state_d     = IDLE;
               cnt_d       = '0;
               miso_d      = 1'b1;
               frame_err_d = 1'b1;
            end else if (sck_fall) begin
               miso_d = tx_q[WIDTH-1];
               tx_d   = {tx_q[WIDTH-2:0], 1'b0};
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = RX;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            miso_d  = 1'b1;
         end
      endcase
   end

   assign bus.miso      = miso_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_xform_slave.sv
// Self-checking bench for spi_xform_slave. It drives 8-bit and 16-bit instances from one SPI master.
// Received words are scoreboarded, and returned bits are checked together with their timing.
module tb_spi_xform_slave;

   localparam int SYNC = 2;
   localparam int HALF = 6;

   logic       clock = 1'b0;
   logic       reset;
   logic       sck;
   logic       ss;
   logic       mosi;
   logic [1:0] mode;

   always #5 clock = ~clock;

   spi_xform_slave_if #(.WIDTH(8))  if8 ();
   spi_xform_slave_if #(.WIDTH(16)) if16 ();

   assign if8.sck   = sck;
   assign if8.ss    = ss;
   assign if8.mosi  = mosi;
   assign if8.mode  = mode;
   assign if16.sck  = sck;
   assign if16.ss   = ss;
   assign if16.mosi = mosi;
   assign if16.mode = mode;

   spi_xform_slave #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (if8)
   );

   spi_xform_slave #(.WIDTH(16), .SYNC_STAGES(SYNC)) dut16 (
      .clock (clock),
      .reset (reset),
      .bus   (if16)
   );

   int          assertCount = 0;
   int          failCount   = 0;
   int          rvCount     = 0;
   int          feCount     = 0;
   bit          sel16       = 1'b0;
   logic [31:0] expRx[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic curMiso();
      return sel16 ? if16.miso : if8.miso;
   endfunction

   function automatic logic [31:0] curRxData();
      return sel16 ? 32'(if16.rx_data) : 32'(if8.rx_data);
   endfunction

   function automatic logic [31:0] xformModel(input logic [31:0] w, input int width, input logic [1:0] m);
      logic [31:0] r;
      logic [31:0] mask;
      r    = '0;
      mask = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      for (int i = 0; i < width; i++) begin
         r[width-1-i] = w[i];
      end
      case (m)
         2'd0:    return r;
         2'd1:    return w & mask;
         2'd2:    return ~w & mask;
         default: return ~r & mask;
      endcase
   endfunction

   // Every completed word is popped against what the master sent. Pulses are counted for delta checks.
   always @(negedge clock) begin
      if (!reset) begin
         if (sel16 ? if16.rx_valid : if8.rx_valid) begin
            rvCount++;
            if (expRx.size() == 0) begin
               checkOutput("rx_unexpected", 32'd1, 32'd0);
            end else begin
               checkOutput("rx_data", curRxData(), expRx.pop_front());
            end
         end
         if (sel16 ? if16.frame_err : if8.frame_err) begin
            feCount++;
         end
      end
   end

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic applyStimulus(input logic [31:0] word, input int width, input logic [1:0] m);
      mode = m;
      expRx.push_back(word);
      for (int i = width - 1; i >= 0; i--) begin
         mosi = word[i];
         waitClocks(HALF);
         sck = 1'b1;
         waitClocks(HALF);
         if (i > 0) begin
            sck = 1'b0;
         end
      end
   endtask

   task automatic partialBits(input logic [31:0] word, input int width, input int n);
      for (int i = 0; i < n; i++) begin
         mosi = word[width-1-i];
         waitClocks(HALF);
         sck = 1'b1;
         waitClocks(HALF);
         sck = 1'b0;
      end
   endtask

   // The bench drives each fall and then checks miso twice. The first check is one clock before the update is due.
   // The second check is exactly when the detected fall has been registered.
   task automatic readTx(input logic [31:0] expWord, input int width, input int nbits,
                         input bit changeMode, input logic [1:0] midMode);
      logic prevBit;
      logic b;
      prevBit = 1'b1;
      for (int k = 0; k < nbits; k++) begin
         b    = expWord[width-1-k];
         sck  = 1'b0;
         mosi = 1'($urandom_range(0, 1));
         repeat (SYNC) @(posedge clock);
         #1 checkOutput("miso_pre_edge", 32'(curMiso()), 32'(prevBit));
         @(posedge clock);
         #1 checkOutput("miso_bit", 32'(curMiso()), 32'(b));
         if (changeMode && k == 0) begin
            mode = midMode;
         end
         waitClocks(HALF - 2);
         if (k < nbits - 1) begin
            sck = 1'b1;
            waitClocks(HALF);
         end
         prevBit = b;
      end
      if (nbits == width) begin
         @(posedge clock);
         #1 checkOutput("miso_hold_last", 32'(curMiso()), 32'(prevBit));
         @(negedge clock);
      end
   endtask

   task automatic endFrame();
      ss = 1'b1;
      waitClocks(SYNC + 3);
      @(posedge clock);
      #1 checkOutput("miso_idle", 32'(curMiso()), 32'd1);
      @(negedge clock);
   endtask

   initial begin
      int          rv0;
      int          fe0;
      logic [31:0] w;
      logic [1:0]  m;

      sck   = 1'b0;
      ss    = 1'b1;
      mosi  = 1'b0;
      mode  = 2'b00;
      reset = 1'b1;
      waitClocks(4);
      @(posedge clock);
      #1;
      checkOutput("rst_miso8", 32'(if8.miso), 32'd1);
      checkOutput("rst_rxv8", 32'(if8.rx_valid), 32'd0);
      checkOutput("rst_fe8", 32'(if8.frame_err), 32'd0);
      checkOutput("rst_rxd8", 32'(if8.rx_data), 32'd0);
      checkOutput("rst_miso16", 32'(if16.miso), 32'd1);
      checkOutput("rst_rxd16", 32'(if16.rx_data), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      waitClocks(4);

      $display("[TB] mode 00 single word 0x01");
      rv0 = rvCount; fe0 = feCount;
      ss = 1'b0; waitClocks(HALF);
      applyStimulus(32'h01, 8, 2'b00);
      readTx(32'h80, 8, 8, 1'b0, 2'b00);
      endFrame();
      checkOutput("t1_rx_pulses", 32'(rvCount - rv0), 32'd1);
      checkOutput("t1_frame_err", 32'(feCount - fe0), 32'd0);

      $display("[TB] mode 10 back-to-back 0xA5, 0x3C");
      rv0 = rvCount; fe0 = feCount;
      ss = 1'b0; waitClocks(HALF);
      applyStimulus(32'hA5, 8, 2'b10);
      readTx(32'h5A, 8, 8, 1'b0, 2'b00);
      applyStimulus(32'h3C, 8, 2'b10);
      readTx(32'hC3, 8, 8, 1'b0, 2'b00);
      endFrame();
      checkOutput("t2_rx_pulses", 32'(rvCount - rv0), 32'd2);
      checkOutput("t2_frame_err", 32'(feCount - fe0), 32'd0);

      $display("[TB] mode 11 with mode change during transmit");
      ss = 1'b0; waitClocks(HALF);
      applyStimulus(32'h01, 8, 2'b11);
      readTx(32'h7F, 8, 8, 1'b1, 2'b01);
      endFrame();

      $display("[TB] abort after 3 bits, then 0x0F");
      rv0 = rvCount; fe0 = feCount;
      ss = 1'b0; waitClocks(HALF);
      partialBits(32'hE0, 8, 3);
      ss = 1'b1;
      waitClocks(SYNC + 4);
      @(posedge clock);
      #1 checkOutput("t4_miso_after_abort", 32'(curMiso()), 32'd1);
      @(negedge clock);
      checkOutput("t4_frame_err", 32'(feCount - fe0), 32'd1);
      checkOutput("t4_rx_pulses", 32'(rvCount - rv0), 32'd0);
      mode = 2'b00;
      ss = 1'b0; waitClocks(HALF);
      applyStimulus(32'h0F, 8, 2'b00);
      readTx(32'hF0, 8, 8, 1'b0, 2'b00);
      endFrame();

      $display("[TB] select released on the final rise");
      rv0 = rvCount; fe0 = feCount;
      ss = 1'b0; waitClocks(HALF);
      partialBits(32'h5B, 8, 7);
      mosi = 1'b1;
      waitClocks(HALF);
      sck = 1'b1;
      ss  = 1'b1;
      waitClocks(HALF);
      sck = 1'b0;
      waitClocks(HALF);
      checkOutput("t5_frame_err", 32'(feCount - fe0), 32'd1);
      checkOutput("t5_rx_pulses", 32'(rvCount - rv0), 32'd0);

      $display("[TB] reset during transmit");
      ss = 1'b0; waitClocks(HALF);
      applyStimulus(32'h35, 8, 2'b00);
      readTx(32'hAC, 8, 4, 1'b0, 2'b00);
      reset = 1'b1;
      ss    = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("t6_miso_reset", 32'(if8.miso), 32'd1);
      checkOutput("t6_rxv_reset", 32'(if8.rx_valid), 32'd0);
      waitClocks(3);
      reset = 1'b0;
      waitClocks(4);
      ss = 1'b0; waitClocks(HALF);
      applyStimulus(32'h80, 8, 2'b00);
      readTx(32'h01, 8, 8, 1'b0, 2'b00);
      endFrame();

      $display("[TB] random back-to-back words");
      rv0 = rvCount; fe0 = feCount;
      ss = 1'b0; waitClocks(HALF);
      for (int n = 0; n < 4; n++) begin
         w = 32'($urandom_range(0, 255));
         m = 2'($urandom_range(0, 3));
         applyStimulus(w, 8, m);
         readTx(xformModel(w, 8, m), 8, 8, 1'b0, 2'b00);
      end
      endFrame();
      checkOutput("t7_rx_pulses", 32'(rvCount - rv0), 32'd4);
      checkOutput("t7_frame_err", 32'(feCount - fe0), 32'd0);

      $display("[TB] 16-bit mode 00 word 0x1234");
      sel16 = 1'b1;
      waitClocks(2);
      rv0 = rvCount; fe0 = feCount;
      ss = 1'b0; waitClocks(HALF);
      applyStimulus(32'h1234, 16, 2'b00);
      readTx(32'h2C48, 16, 16, 1'b0, 2'b00);
      endFrame();
      checkOutput("t8_rx_pulses", 32'(rvCount - rv0), 32'd1);
      checkOutput("t8_frame_err", 32'(feCount - fe0), 32'd0);

      checkOutput("rx_pending", 32'(expRx.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/spi_xform_slave.md
SPI_XFORM_SLAVE -- requirements
Module: spi_xform_slave

Parameters
REQ-001 SHALL provide WIDTH, default 8, word length in bits (legal: 4..32).
REQ-002 SHALL provide SYNC_STAGES, default 2, flip-flop stages on sck/ss/mosi (legal: 2..4).

Interface
REQ-003 SHALL have clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have sck  input  1  SPI clock, asynchronous to clock, idle low (mode 0).
REQ-006 SHALL have ss  input  1  SPI select, active-low, asynchronous.
REQ-007 SHALL have mosi  input  1  serial data in, MSB first.
REQ-008 SHALL have mode  input  2  transform select: 00 bit-reverse, 01 echo, 10 invert, 11 reverse+invert.
REQ-009 SHALL have miso  output  1  serial data out, MSB first; 1 when not transmitting.
REQ-010 SHALL have rx_valid  output  1  one-clock pulse when a word has been received.
REQ-011 SHALL have rx_data  output  WIDTH  last received word, held until the next rx_valid.
REQ-012 SHALL have frame_err  output  1  one-clock pulse when ss deasserts mid-word.

Function
REQ-013 sck, ss and mosi SHALL pass through SYNC_STAGES synchronizer flops; edges SHALL be detected from the synchronized sck against its previous value.
REQ-014 sck high and low phases SHALL each be at least SYNC_STAGES+2 clock periods; shorter phases are out of contract.
REQ-015 States SHALL be IDLE, RX and TX, with a bit counter of $clog2(WIDTH) bits.
REQ-016 IDLE: when synchronized ss is low, go to RX, counter=0, miso=1.
REQ-017 RX: on each detected sck rise, shift synchronized mosi into the shift register LSB and increment the counter; miso stays 1.
REQ-018 RX: on the WIDTH-th rise, in the same clock, set rx_data to the complete word, pulse rx_valid, load the transform of the word per mode (sampled that clock) into the tx register, reset the counter to 0, and go to TX.
REQ-019 TX: on each detected sck fall, drive miso from the tx register MSB and shift left; after WIDTH falls, go to RX for the next word (back-to-back words without ss release).
REQ-020 TX: the master samples the k-th TX bit on the sck rise following the k-th fall; sck rises in TX SHALL NOT capture data.
REQ-021 The final TX bit SHALL hold on miso until the next detected fall (miso returns to 1) or until ss rises.
REQ-022 miso SHALL be registered and SHALL change exactly one clock after the detected edge.
REQ-023 Synchronized ss going high in any state SHALL force IDLE, counter=0, miso=1 in the next clock.
REQ-024 frame_err SHALL pulse when ss goes high with RX counter != 0 or in TX with bits remaining; ss going high in IDLE, in RX with counter 0, or after the last TX bit SHALL NOT pulse it.
REQ-025 If ss going high coincides with the WIDTH-th rise, the word SHALL be dropped: no rx_valid and frame_err pulsed.
REQ-026 mode changes outside the REQ-018 sample clock SHALL NOT affect the word in flight.

Reset
REQ-027 On reset: state=IDLE, counter=0, shift/tx registers=0, rx_data=0, miso=1, rx_valid=0, frame_err=0, synchronizer flops set to sck=0, ss=1, mosi=0.
REQ-028 Reset SHALL override all other activity, including mid-TX; after release the block SHALL wait for ss low (synchronized) before receiving.

Verification
REQ-029 WIDTH=8, mode=00, send 0x01 -> rx_valid with rx_data=0x01; miso returns 0x80 over the next 8 sck cycles.
REQ-030 WIDTH=8, mode=10, send 0xA5 then 0x3C back-to-back under one ss -> returns 0x5A then 0xC3; two rx_valid pulses; no frame_err.
REQ-031 WIDTH=8, mode=11, send 0x01 -> returns 0x7F; mode switched to 01 during TX -> output still 0x7F.
REQ-032 WIDTH=8, raise ss after 3 bits -> one frame_err pulse, no rx_valid, miso=1; next full frame 0x0F with mode 00 -> returns 0xF0.
REQ-033 WIDTH=8, assert reset after 4 TX bits -> miso=1 and rx_valid=0 next clock; a fresh frame 0x80 with mode 00 returns 0x01.
REQ-034 WIDTH=16, mode=00, send 0x1234 -> rx_data=0x1234, miso returns 0x2C48; all miso changes occur 1 clock after detected sck falls.
